// File: rtl/bar_channel_scheduler.sv
// Issue sequencer for the 9-tap multiplier bar: pairs weight sets with activation windows,
// accumulates the bar's per-channel partial results and emits one saturated byte per pixel.
module bar_channel_scheduler #(
    parameter int CH_MAX  = 64,
    parameter int BAR_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  cfg_num_ch,
    input  logic [15:0] cfg_num_pix,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [71:0] w_data,
    input  logic        win_valid,
    output logic        win_ready,
    input  logic [71:0] win_data,
    output logic [71:0] bar_in,
    output logic [71:0] bar_w,
    output logic        bar_valid_i,
    input  logic [7:0]  bar_out,
    input  logic        bar_valid_o,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        busy,
    output logic        done
);

    localparam int CH_W  = $clog2(CH_MAX + 1);
    localparam int ACC_W = 8 + $clog2(CH_MAX);
    localparam int OUT_W = $clog2(BAR_LAT + 2) + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_reg;
    logic [CH_W-1:0]          num_ch_m1_reg;
    logic [15:0]              num_pix_m1_reg;
    logic [CH_W-1:0]          ch_iss_reg;
    logic [15:0]              pix_iss_reg;
    logic [CH_W-1:0]          ch_acc_reg;
    logic [15:0]              pix_acc_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     fin_reg;
    logic [OUT_W-1:0]         out_cnt_reg;

    logic                     hs;
    logic                     acc_en;
    logic                     last_issue;
    logic signed [ACC_W-1:0]  bar_sext;
    logic signed [ACC_W-1:0]  acc_next;
    logic [7:0]               sat_val;

    // Both streams move together or not at all.
    assign hs         = (state_reg == S_RUN) && w_valid && win_valid;
    assign w_ready    = hs;
    assign win_ready  = hs;
    assign last_issue = (ch_iss_reg == num_ch_m1_reg) && (pix_iss_reg == num_pix_m1_reg);

    // Strobes are only taken while a job is active and something is actually in the bar.
    assign acc_en = bar_valid_o && !fin_reg && (out_cnt_reg != '0)
                 && ((state_reg == S_RUN) || (state_reg == S_DRAIN));

    always_comb begin
        bar_sext = {{(ACC_W-8){bar_out[7]}}, bar_out};
        acc_next = (ch_acc_reg == '0) ? bar_sext : acc_reg + bar_sext;
        if (acc_next > SAT_HI) begin
            sat_val = 8'h7f;
        end else if (acc_next < SAT_LO) begin
            sat_val = 8'h80;
        end else begin
            sat_val = acc_next[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            num_ch_m1_reg  <= '0;
            num_pix_m1_reg <= '0;
            ch_iss_reg     <= '0;
            pix_iss_reg    <= '0;
            ch_acc_reg     <= '0;
            pix_acc_reg    <= '0;
            acc_reg        <= '0;
            fin_reg        <= 1'b0;
            out_cnt_reg    <= '0;
            bar_in         <= '0;
            bar_w          <= '0;
            bar_valid_i    <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            bar_valid_i <= 1'b0;
            res_valid   <= 1'b0;
            done        <= 1'b0;

            if (hs) begin
                bar_in      <= win_data;
                bar_w       <= w_data;
                bar_valid_i <= 1'b1;
                if (ch_iss_reg == num_ch_m1_reg) begin
                    ch_iss_reg  <= '0;
                    pix_iss_reg <= pix_iss_reg + 16'd1;
                end else begin
                    ch_iss_reg <= ch_iss_reg + CH_W'(1);
                end
            end

            if (acc_en) begin
                acc_reg <= acc_next;
                if (ch_acc_reg == num_ch_m1_reg) begin
                    res_data    <= sat_val;
                    res_valid   <= 1'b1;
                    ch_acc_reg  <= '0;
                    pix_acc_reg <= pix_acc_reg + 16'd1;
                    if (pix_acc_reg == num_pix_m1_reg) begin
                        fin_reg <= 1'b1;
                    end
                end else begin
                    ch_acc_reg <= ch_acc_reg + CH_W'(1);
                end
            end

            if (hs && !acc_en) begin
                out_cnt_reg <= out_cnt_reg + OUT_W'(1);
            end else if (!hs && acc_en) begin
                out_cnt_reg <= out_cnt_reg - OUT_W'(1);
            end

            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_ch_m1_reg  <= CH_W'(cfg_num_ch - 7'd1);
                        num_pix_m1_reg <= cfg_num_pix - 16'd1;
                        ch_iss_reg     <= '0;
                        pix_iss_reg    <= '0;
                        ch_acc_reg     <= '0;
                        pix_acc_reg    <= '0;
                        acc_reg        <= '0;
                        fin_reg        <= 1'b0;
                        out_cnt_reg    <= '0;
                        if ((cfg_num_ch == 7'd0) || (cfg_num_pix == 16'd0)) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= S_RUN;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (hs && last_issue) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // fin_reg rises with the final res_valid, so done trails it by one cycle.
                    if (fin_reg) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    fin_reg   <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_channel_scheduler.sv
// Directed bench for bar_channel_scheduler with a fixed-latency dot-product bar stub.
module tb_bar_channel_scheduler;

    localparam int BAR_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  cfg_num_ch = '0;
    logic [15:0] cfg_num_pix = '0;
    logic        w_valid = 1'b0;
    logic        win_valid = 1'b0;
    logic [71:0] w_data = '0;
    logic [71:0] win_data = '0;
    logic        w_ready, win_ready;
    logic [71:0] bar_in, bar_w;
    logic        bar_valid_i;
    logic [7:0]  bar_out;
    logic        bar_valid_o;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    bar_channel_scheduler #(.CH_MAX(64), .BAR_LAT(BAR_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .bar_in(bar_in), .bar_w(bar_w), .bar_valid_i(bar_valid_i),
        .bar_out(bar_out), .bar_valid_o(bar_valid_o),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bar stub: saturated 9-tap dot product, BAR_LAT cycles after bar_valid_i.
    function automatic logic [7:0] bar_func(input logic [71:0] a, input logic [71:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            s += $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    logic [BAR_LAT-1:0] bv_pipe = '0;
    logic [7:0]         bo_pipe [BAR_LAT];

    always @(posedge clk) begin
        bv_pipe    <= {bv_pipe[BAR_LAT-2:0], bar_valid_i};
        bo_pipe[0] <= bar_func(bar_in, bar_w);
        for (int i = 1; i < BAR_LAT; i++) bo_pipe[i] <= bo_pipe[i-1];
    end
    assign bar_valid_o = bv_pipe[BAR_LAT-1];
    assign bar_out     = bo_pipe[BAR_LAT-1];

    // Event monitor, sampled on the falling edge.
    int         n_iss = 0, n_res = 0, n_done = 0, n_busy = 0;
    logic [7:0] res_arr [64];

    always @(negedge clk) begin
        if (bar_valid_i) n_iss <= n_iss + 1;
        if (res_valid) begin
            res_arr[n_res % 64] <= res_data;
            n_res <= n_res + 1;
        end
        if (done) n_done <= n_done + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    logic [71:0] w_mem   [16];
    logic [71:0] win_mem [16];
    int          res_base;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] px1(input int v);
        logic [71:0] r;
        r = '0;
        r[7:0] = 8'(v);
        return r;
    endfunction

    // Streams nch*npix pairs from w_mem/win_mem, then waits (bounded) for done.
    task automatic run_job(input logic [6:0] nch, input logic [15:0] npix, input bit rnd, input bit poke);
        int idx, guard, total, b_iss, b_done;
        b_iss    = n_iss;
        b_done   = n_done;
        res_base = n_res;
        total    = int'(nch) * int'(npix);
        @(negedge clk);
        start = 1'b1; cfg_num_ch = nch; cfg_num_pix = npix;
        idx = 0; guard = 0;
        while (idx < total && guard < 400) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            w_data    = w_mem[idx];
            win_data  = win_mem[idx];
            w_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            win_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && idx == 1) begin
                start = 1'b1; cfg_num_ch = 7'd3; cfg_num_pix = 16'd5;
            end
            #1;
            chk("ready_join", {70'd0, w_ready, win_ready}, {70'd0, {2{w_valid & win_valid}}});
            if (w_valid && win_valid) idx++;
        end
        @(negedge clk);
        start = 1'b0; w_valid = 1'b1; win_valid = 1'b1;
        #1 chk("drain_no_xfer", {71'd0, w_ready}, 72'd0);
        @(negedge clk);
        w_valid = 1'b0; win_valid = 1'b0;
        guard = 0;
        while (n_done == b_done && guard < 60) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("done_seen", 72'(n_done != b_done), 72'd1);
        @(negedge clk); #1;
        chk("done_once", 72'(n_done - b_done), 72'd1);
        chk("iss_count", 72'(n_iss - b_iss), 72'(total));
        chk("res_count", 72'(n_res - res_base), 72'(npix));
        chk("busy_low_after", {71'd0, busy}, 72'd0);
        $display("[TB] job ch=%0d pix=%0d issues=%0d results=%0d", nch, npix, n_iss - b_iss, n_res - res_base);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_res, b_busy;

        // Reset state
        @(negedge clk); #1;
        chk("rst_bar_in", bar_in, 72'd0);
        chk("rst_bar_w", bar_w, 72'd0);
        chk("rst_ctrl", {61'd0, res_data, bar_valid_i, res_valid, busy}, 72'd0);
        chk("rst_hs", {69'd0, w_ready, win_ready, done}, 72'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_busy", {71'd0, busy}, 72'd0);

        // Single channel, single pixel: exact latency profile
        b_res = n_res;
        @(negedge clk);
        start = 1'b1; cfg_num_ch = 7'd1; cfg_num_pix = 16'd1;
        @(negedge clk);
        start = 1'b0;
        #1 chk("busy_rise", {71'd0, busy}, 72'd1);
        w_valid = 1'b1; win_valid = 1'b1;
        w_data   = {9{8'h01}};
        win_data = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        #1 chk("t1_ready", {71'd0, w_ready}, 72'd1);
        @(negedge clk);
        w_valid = 1'b0; win_valid = 1'b0;
        #1;
        chk("t1_issue", {71'd0, bar_valid_i}, 72'd1);
        chk("t1_bar_in", bar_in, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        chk("t1_bar_w", bar_w, {9{8'h01}});
        @(negedge clk); #1;
        chk("t1_issue_drop", {71'd0, bar_valid_i}, 72'd0);
        chk("t1_hold", bar_in, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        repeat (3) begin
            @(negedge clk); #1;
            chk("t1_no_early_res", {71'd0, res_valid}, 72'd0);
        end
        @(negedge clk); #1;
        chk("t1_res_valid", {71'd0, res_valid}, 72'd1);
        chk("t1_res_data", {64'd0, res_data}, 72'd45);
        chk("t1_done_not_yet", {71'd0, done}, 72'd0);
        @(negedge clk); #1;
        chk("t1_done", {71'd0, done}, 72'd1);
        chk("t1_busy_low", {71'd0, busy}, 72'd0);
        chk("t1_res_drop", {71'd0, res_valid}, 72'd0);
        @(negedge clk); #1;
        chk("t1_done_pulse", {71'd0, done}, 72'd0);
        chk("t1_res_count", 72'(n_res - b_res), 72'd1);
        $display("[TB] job ch=1 pix=1 result=%0d", $signed(res_arr[b_res % 64]));

        // Channel accumulation: 10 + 20 - 5
        for (int i = 0; i < 3; i++) w_mem[i] = px1(1);
        win_mem[0] = px1(10); win_mem[1] = px1(20); win_mem[2] = px1(-5);
        run_job(7'd3, 16'd1, 1'b0, 1'b0);
        chk("acc_res", {64'd0, res_arr[res_base % 64]}, 72'h19);

        // Saturation high then low, across two pixels of one job
        for (int i = 0; i < 8; i++) begin
            w_mem[i]   = px1(1);
            win_mem[i] = px1(i < 4 ? 100 : -100);
        end
        run_job(7'd4, 16'd2, 1'b0, 1'b0);
        chk("sat_hi", {64'd0, res_arr[res_base % 64]}, 72'h7f);
        chk("sat_lo", {64'd0, res_arr[(res_base + 1) % 64]}, 72'h80);

        // Random independent stalls on both streams
        for (int i = 0; i < 6; i++) w_mem[i] = px1(1);
        win_mem[0] = px1(5);   win_mem[1] = px1(6);
        win_mem[2] = px1(7);   win_mem[3] = px1(-20);
        win_mem[4] = px1(100); win_mem[5] = px1(100);
        run_job(7'd2, 16'd3, 1'b1, 1'b0);
        chk("stall_res0", {64'd0, res_arr[res_base % 64]}, 72'h0b);
        chk("stall_res1", {64'd0, res_arr[(res_base + 1) % 64]}, 72'hf3);
        chk("stall_res2", {64'd0, res_arr[(res_base + 2) % 64]}, 72'h7f);

        // Empty job: num_pix = 0
        b_busy = n_busy;
        b_res  = n_res;
        @(negedge clk);
        start = 1'b1; cfg_num_ch = 7'd3; cfg_num_pix = 16'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("empty_done", {71'd0, done}, 72'd1);
        chk("empty_busy", {71'd0, busy}, 72'd0);
        @(negedge clk); #1;
        chk("empty_done_pulse", {71'd0, done}, 72'd0);
        chk("empty_busy_never", 72'(n_busy - b_busy), 72'd0);
        chk("empty_no_res", 72'(n_res - b_res), 72'd0);
        // Empty job: num_ch = 0
        @(negedge clk);
        start = 1'b1; cfg_num_ch = 7'd0; cfg_num_pix = 16'd4;
        @(negedge clk);
        start = 1'b0;
        #1 chk("empty_ch_done", {71'd0, done}, 72'd1);
        $display("[TB] empty jobs done");

        // start pulse during RUN must not reconfigure the job
        w_mem[0] = px1(1); w_mem[1] = px1(1);
        win_mem[0] = px1(7); win_mem[1] = px1(9);
        run_job(7'd1, 16'd2, 1'b0, 1'b1);
        chk("poke_res0", {64'd0, res_arr[res_base % 64]}, 72'd7);
        chk("poke_res1", {64'd0, res_arr[(res_base + 1) % 64]}, 72'd9);

        // Reset during DRAIN with two results still in the bar
        b_res = n_res;
        @(negedge clk);
        start = 1'b1; cfg_num_ch = 7'd1; cfg_num_pix = 16'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; w_valid = 1'b1; win_valid = 1'b1;
            w_data = px1(1); win_data = px1(k + 3);
        end
        @(negedge clk);
        w_valid = 1'b0; win_valid = 1'b0;
        #1 chk("mid_busy", {71'd0, busy}, 72'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_first_res", {63'd0, res_valid, res_data}, {63'd0, 1'b1, 8'd3});
        rst = 1'b1;
        #1;
        chk("mid_rst_bar_in", bar_in, 72'd0);
        chk("mid_rst_bar_w", bar_w, 72'd0);
        chk("mid_rst_ctrl", {61'd0, res_data, bar_valid_i, res_valid, busy}, 72'd0);
        chk("mid_rst_hs", {69'd0, w_ready, win_ready, done}, 72'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("mid_no_stale", 72'(n_res - b_res), 72'd1);
        $display("[TB] reset mid-job results=%0d", n_res - b_res);

        // Fresh job after reset
        w_mem[0] = {9{8'h02}}; win_mem[0] = {9{8'h03}};
        run_job(7'd1, 16'd1, 1'b0, 1'b0);
        chk("fresh_res", {64'd0, res_arr[res_base % 64]}, 72'd54);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_channel_scheduler.md
# bar_channel_scheduler

Sequencer for the 9-tap multiplier bar: pairs a 3×3 weight set with a 3×3 activation window, issues one bar operation per channel per output pixel, and accumulates the bar's 8-bit partial results across input channels. It produces one saturated 8-bit result per output pixel. The block sits between the window/weight buffers and the bar, and drives the bar's inputs and `valid_i` directly.

## Interface
- `CH_MAX`, default 64: maximum input channels per pixel; sets the counter widths.
- `BAR_LAT`, default 4: bar latency from `valid_i` to `valid_o`, in cycles. Informational; the accumulator is driven by `bar_valid_o`, not by a timer.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches the configuration. Accepted only in IDLE.
- `cfg_num_ch` in 7: input channels per pixel, range 1..CH_MAX. A value of 0 means an empty job.
- `cfg_num_pix` in 16: output pixels in the job. A value of 0 means an empty job.
- `w_valid`, `w_ready` in/out 1: handshake for the weight-set stream.
- `w_data` in 72: nine signed 8-bit weights; w1 is in [7:0] and w9 is in [71:64].
- `win_valid`, `win_ready` in/out 1: handshake for the activation-window stream.
- `win_data` in 72: nine signed 8-bit pixels, packed the same way as `w_data`.
- `bar_in` out 72: registered window driven to the bar's in1..in9.
- `bar_w` out 72: registered weights driven to the bar's w1..w9.
- `bar_valid_i` out 1: issue strobe to the bar.
- `bar_out` in 8: signed 8-bit bar result.
- `bar_valid_o` in 1: bar result strobe.
- `res_valid` out 1: one-cycle strobe marking a pixel result.
- `res_data` out 8: saturated signed pixel result.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at the end of a job.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`, latch `cfg_num_ch` and `cfg_num_pix`.
  - If either value is 0, go to DONE. Otherwise go to RUN.
  - `start` in any other state is ignored.
- RUN, joined handshake:
  - `w_ready = win_ready = RUN & w_valid & win_valid`.
  - Both streams transfer in the same cycle or neither does. One issue is allowed per cycle.
- Issue counters:
  - `ch_iss` counts 0..num_ch-1 and wraps to 0.
  - `pix_iss` increments on each `ch_iss` wrap.
  - The issue with `ch_iss == num_ch-1` and `pix_iss == num_pix-1` is the last issue; RUN → DRAIN on that cycle.
- DRAIN: no transfers. DRAIN → DONE in the cycle the last result is accumulated.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Accumulator, signed 14-bit, updated only on `bar_valid_o`:
  - If `ch_acc == 0`: `acc ← sext(bar_out)`.
  - Otherwise: `acc ← acc + sext(bar_out)`.
  - 14 bits covers 64 × (−128..127) without overflow.
- Result emission:
  - When `ch_acc == num_ch-1`, register `res_data = sat8(acc_next)` and `res_valid = 1`.
  - `sat8` clamps to the range −128..127.
  - Then `ch_acc → 0` and `pix_acc` increments.
  - The accumulation with `pix_acc == num_pix-1` and `ch_acc == num_ch-1` is the last result.
- `bar_valid_o` outside RUN/DRAIN is ignored; the counters do not move.
- There is no backpressure on results; the consumer must accept one per cycle.

## Timing
- Reset values:
  - Outputs: `bar_in`, `bar_w`, `res_data` = 0; `bar_valid_i`, `res_valid`, `busy`, `done`, `w_ready`, `win_ready` = 0.
  - Internal: state IDLE; all counters and `acc` = 0.
- Issue path: a handshake in cycle T gives `bar_in`, `bar_w` and `bar_valid_i = 1` in T+1. With no handshake, `bar_valid_i = 0` and the data is held.
- Bar response: `bar_valid_o` arrives at T+1+BAR_LAT, i.e. T+5 with the default latency.
- Result latency:
  - `res_valid` is asserted 1 cycle after the last channel's `bar_valid_o`.
  - For `num_ch = 1`: handshake at T, `res_valid` at T+6.
- Job start: `busy` rises the cycle after `start`. `done` is asserted 1 cycle after the last `res_valid` cycle; `busy` is low in that same cycle.
- Empty job: `start` at T gives `done` at T+1, with no `res_valid` and no issues.
- Throughput:
  - One issue per cycle under continuous valid inputs.
  - One result every `num_ch` cycles.
  - When `num_ch = 1`, `res_valid` may be asserted every cycle.
- Reset mid-job: everything returns to reset values immediately. Results still in the bar pipeline after reset are ignored because the state is IDLE.

## Test plan
- Single channel, single pixel:
  - Stimulus: `num_ch = 1`, `num_pix = 1`; all weights 1; window pixels 1..9.
  - Required: `bar_valid_i` one cycle after the handshake; `res_data` = bar output for 45; `res_valid` at T+6; `done` at T+7.
- Channel accumulation:
  - Stimulus: `num_ch = 3`; the bar model returns 10, 20, −5.
  - Required: `res_data = 25`; exactly one `res_valid` pulse.
- Saturation:
  - Stimulus: `num_ch = 4`, with bar outputs all 100.
  - Required: `res_data = 127`.
  - Stimulus: bar outputs all −100.
  - Required: `res_data = −128`.
- Handshake stalls:
  - Stimulus: `num_ch = 2`, `num_pix = 3`; `w_valid` and `win_valid` toggled randomly and independently.
  - Required: no transfer unless both are valid; exactly 6 `bar_valid_i` pulses; 3 results in order; `done` once.
- Edge configurations:
  - Stimulus: `num_pix = 0`.
    - Required: `done` one cycle after `start`; `busy` never set.
  - Stimulus: `start` during RUN.
    - Required: ignored; the counters are unchanged.
- Reset mid-job:
  - Stimulus: assert `rst` during DRAIN with 2 results in flight.
  - Required: all outputs return to 0 immediately.
  - Required: a fresh job after reset (`num_ch = 1`, `num_pix = 1`) returns the correct result with no stale `res_valid`.
